fpu_addsub_issue: RTL and testbench

- Issue and writeback stage wrapped around the combinational single-precision adder.
- Accepts fadd/fsub/fneg/fabs requests from the decode stage through a small request queue.
- Drives the adder's two operand inputs from the queue head, captures the adder output into a result register, and hands the result plus destination tag to writeback over a valid/ready handshake.
- Does not instantiate the adder: exposes an operand/result port pair that the top level wires to it.

---
 rtl/fpu_addsub_issue.sv | 212 +++++++++++++++++++++
 tb/tb_fpu_addsub_issue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_issue.sv
// ---------------------------------------------------------------------------
// fpu_addsub_issue
//
// Issue and writeback stage for the combinational single-precision adder.
// The decode stage pushes fadd/fsub/fneg/fabs requests into a small circular
// queue. The queue head drives the adder operands. The adder result, or the
// locally computed fneg/fabs value, is captured into a result register. That
// register is handed to writeback over a valid/ready handshake. The adder is
// not instantiated here; add_x1/add_x2/add_y are wired to it at the top level.
//
// Parameters:
//   DEPTH  request queue entries (1..8)
//   TAG_W  destination register tag width
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   flush            synchronous flush, highest priority
//   in_valid/ready   request handshake (in_ready = queue not full)
//   in_op            00 fadd, 01 fsub, 10 fneg, 11 fabs
//   in_a, in_b       IEEE-754 single operands (in_b unused for fneg/fabs)
//   in_tag           destination tag
//   add_x1, add_x2   adder operands driven from the queue head
//   add_y            adder result (combinational)
//   out_valid/ready  result handshake
//   out_data/tag     registered result and tag
//   busy             queue non-empty or result pending
//
// Optional feature (macro FPU_ADDSUB_FTZ_EN):
//   When defined, fadd/fsub operands and results with a zero exponent are
//   flushed to signed zero. When undefined, subnormals pass unmodified.
// ---------------------------------------------------------------------------
module fpu_addsub_issue #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      add_x1,
    output logic [31:0]      add_x2,
    input  logic [31:0]      add_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        OP_FADD = 2'b00,
        OP_FSUB = 2'b01,
        OP_FNEG = 2'b10,
        OP_FABS = 2'b11
    } op_e;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

`ifdef FPU_ADDSUB_FTZ_EN
    // Replace a zero-exponent value (zero or subnormal) by signed zero.
    function automatic logic [31:0] ftz(input logic [31:0] v);
        return (v[30:23] == 8'h00) ? {v[31], 31'b0} : v;
    endfunction
`endif

    // Queue storage and control
    logic [31:0]      r_mem_a   [DEPTH];
    logic [31:0]      r_mem_b   [DEPTH];
    op_e              r_mem_op  [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_full;
    logic             w_head_valid;
    logic             w_push;
    logic             w_adv;
    logic [31:0]      w_head_a;
    logic [31:0]      w_head_b;
    op_e              w_head_op;
    logic [TAG_W-1:0] w_head_tag;
    logic [31:0]      w_x1;
    logic [31:0]      w_x2;
    logic [31:0]      w_result;

    assign w_full       = (r_count == CNT_FULL);
    assign w_head_valid = (r_count != '0);
    assign w_push       = in_valid && !w_full;
    assign w_adv        = w_head_valid && (!r_out_valid || out_ready);

    assign w_head_a   = r_mem_a[r_rptr];
    assign w_head_b   = r_mem_b[r_rptr];
    assign w_head_op  = r_mem_op[r_rptr];
    assign w_head_tag = r_mem_tag[r_rptr];

    // Storage needs no reset: an entry is only read while the count covers it.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_a[r_wptr]   <= in_a;
            r_mem_b[r_wptr]   <= in_b;
            r_mem_op[r_wptr]  <= op_e'(in_op);
            r_mem_tag[r_wptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_adv) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_W'(1);
            end
            if (w_push && !w_adv) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_adv) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Adder feed from the queue head; idle (all zero) for empty queue or fneg/fabs.
    always_comb begin
        w_x1 = '0;
        w_x2 = '0;
        if (w_head_valid) begin
            case (w_head_op)
                OP_FADD: begin
                    w_x1 = w_head_a;
                    w_x2 = w_head_b;
                end
                OP_FSUB: begin
                    w_x1 = w_head_a;
                    w_x2 = {~w_head_b[31], w_head_b[30:0]};
                end
                default: begin
                    w_x1 = '0;
                    w_x2 = '0;
                end
            endcase
        end
`ifdef FPU_ADDSUB_FTZ_EN
        // Applied after the fsub sign flip so the flushed zero keeps the flipped sign.
        w_x1 = ftz(w_x1);
        w_x2 = ftz(w_x2);
`endif
    end

    assign add_x1 = w_x1;
    assign add_x2 = w_x2;

    // Value captured into the result register on advance
    always_comb begin
        w_result = '0;
        case (w_head_op)
            OP_FNEG: w_result = {~w_head_a[31], w_head_a[30:0]};
            OP_FABS: w_result = {1'b0, w_head_a[30:0]};
            default: begin
`ifdef FPU_ADDSUB_FTZ_EN
                w_result = ftz(add_y);
`else
                w_result = add_y;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_tag   <= w_head_tag;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign busy      = w_head_valid || r_out_valid;

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// ---------------------------------------------------------------------------
// tb_fpu_addsub_issue
//
// Directed bench for fpu_addsub_issue (DEPTH=2, TAG_W=6). A small lookup
// stub stands in for the adder: it returns the correctly rounded sum for
// the operand pairs used here, and a fixed marker for anything else.
// ---------------------------------------------------------------------------
module tb_fpu_addsub_issue;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [5:0]  in_tag;
    logic [31:0] add_x1;
    logic [31:0] add_x2;
    logic [31:0] add_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_tag;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    fpu_addsub_issue #(
        .DEPTH (2),
        .TAG_W (6)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .add_x1    (add_x1),
        .add_x2    (add_x2),
        .add_y     (add_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] adder_stub(input logic [31:0] x1, input logic [31:0] x2);
        case ({x1, x2})
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000; // 1 + 2 = 3
            {32'h4040_0000, 32'hBF80_0000}: return 32'h4000_0000; // 3 - 1 = 2
            {32'h0000_0001, 32'h3F80_0000}: return 32'h3F80_0000; // 1 + tiny = 1
            {32'h0000_0000, 32'h3F80_0000}: return 32'h3F80_0000; // 0 + 1 = 1
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb add_y = adder_stub(add_x1, add_x2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, then drop in_valid.
    task automatic push1(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        step();
        in_valid = 1'b0;
    endtask

    // Hold in_valid for n_req fneg requests over 5 cycles; count acceptances.
    task automatic fill_q(input int n_req, input logic [5:0] base, output int n_acc);
        int k;
        logic acc;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (k < n_req);
            in_op    = 2'b10;
            in_a     = 32'h3F80_0000 + 32'(k);
            in_b     = '0;
            in_tag   = base + 6'(k);
            acc      = in_ready;
            step();
            if (in_valid && acc) k++;
        end
        in_valid = 1'b0;
        n_acc    = k;
    endtask

    initial begin
        int n_acc;

        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'h0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_add_x1",    add_x1,         32'h0);
        rstn = 1'b1;
        step();

        // fadd 1.0 + 2.0, tag 5
        push1(2'b00, 32'h3F80_0000, 32'h4000_0000, 6'd5);
        chk("fadd_x1_head",  add_x1,         32'h3F80_0000);
        chk("fadd_x2_head",  add_x2,         32'h4000_0000);
        chk("fadd_notyet",   32'(out_valid), 32'd0);
        step();
        chk("fadd_valid",    32'(out_valid), 32'd1);
        chk("fadd_data",     out_data,       32'h4040_0000);
        chk("fadd_tag",      32'(out_tag),   32'd5);
        chk("fadd_busy",     32'(busy),      32'd1);
        step();
        chk("fadd_drained",  32'(out_valid), 32'd0);
        chk("idle_busy",     32'(busy),      32'd0);

        // fsub 3.0 - 1.0
        push1(2'b01, 32'h4040_0000, 32'h3F80_0000, 6'd7);
        chk("fsub_x2",       add_x2,         32'hBF80_0000);
        step();
        chk("fsub_data",     out_data,       32'h4000_0000);
        chk("fsub_tag",      32'(out_tag),   32'd7);

        // fneg 1.0 (back-to-back with the fsub drain)
        push1(2'b10, 32'h3F80_0000, 32'h1234_5678, 6'd8);
        chk("fneg_x1",       add_x1,         32'h0);
        chk("fneg_x2",       add_x2,         32'h0);
        step();
        chk("fneg_data",     out_data,       32'hBF80_0000);

        // fabs -1.0
        push1(2'b11, 32'hBF80_0000, 32'h0000_1234, 6'd9);
        chk("fabs_x1",       add_x1,         32'h0);
        chk("fabs_x2",       add_x2,         32'h0);
        step();
        chk("fabs_data",     out_data,       32'h3F80_0000);
        chk("fabs_tag",      32'(out_tag),   32'd9);
        step();

        // Backpressure: 4 requests offered, 3 accepted, then full
        out_ready = 1'b0;
        fill_q(4, 6'd10, n_acc);
        chk("fill_accepted", 32'(n_acc),     32'd3);
        chk("fill_in_ready", 32'(in_ready),  32'd0);
        chk("fill_valid",    32'(out_valid), 32'd1);
        chk("fill_busy",     32'(busy),      32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_tag",   32'(out_tag),   32'd10 + 32'(i));
            chk("drain_data",  out_data,       (32'h3F80_0000 + 32'(i)) ^ 32'h8000_0000);
            step();
        end
        chk("drain_empty",   32'(out_valid), 32'd0);
        chk("drain_busy",    32'(busy),      32'd0);

        // Push and advance every cycle at count=1; pointers wrap repeatedly
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_b     = '0;
        in_a     = 32'h0000_0014;
        in_tag   = 6'd20;
        step();
        for (int k = 1; k <= 8; k++) begin
            in_a   = 32'h0000_0014 + 32'(k);
            in_tag = 6'd20 + 6'(k);
            step();
            chk("pp_valid",    32'(out_valid), 32'd1);
            chk("pp_tag",      32'(out_tag),   32'd19 + 32'(k));
            chk("pp_data",     out_data,       32'h8000_0013 + 32'(k));
            chk("pp_in_ready", 32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("pp_last_tag",   32'(out_tag),   32'd28);
        step();
        chk("pp_idle",       32'(out_valid), 32'd0);

        // Flush with result pending, one queued, concurrent push and advance
        out_ready = 1'b0;
        fill_q(2, 6'd30, n_acc);
        chk("fl_setup_acc",  32'(n_acc),     32'd2);
        chk("fl_setup_vld",  32'(out_valid), 32'd1);
        in_valid  = 1'b1;
        in_op     = 2'b10;
        in_a      = 32'h4000_0000;
        in_tag    = 6'd40;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid",      32'(out_valid), 32'd0);
        chk("fl_busy",       32'(busy),      32'd0);
        chk("fl_in_ready",   32'(in_ready),  32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_ghost", 32'(out_valid), 32'd0);
        end

        // Flush while full (count=2, result pending)
        out_ready = 1'b0;
        fill_q(4, 6'd33, n_acc);
        chk("flf_full",      32'(in_ready),  32'd0);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("flf_in_ready",  32'(in_ready),  32'd1);
        chk("flf_busy",      32'(busy),      32'd0);

        // Fresh request after flush starts from reset pointers
        push1(2'b11, 32'hC000_0000, 32'h0, 6'd50);
        step();
        chk("post_fl_tag",   32'(out_tag),   32'd50);
        chk("post_fl_data",  out_data,       32'h4000_0000);
        step();

        // Subnormal operand handling
        push1(2'b00, 32'h0000_0001, 32'h3F80_0000, 6'd3);
`ifdef FPU_ADDSUB_FTZ_EN
        chk("ftz_x1",        add_x1,         32'h0000_0000);
`else
        chk("ftz_x1",        add_x1,         32'h0000_0001);
`endif
        step();
        chk("ftz_data",      out_data,       32'h3F80_0000);
        step();

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        fill_q(2, 6'd60, n_acc);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid",    32'(out_valid), 32'd0);
        chk("arst_busy",     32'(busy),      32'd0);
        chk("arst_tag",      32'(out_tag),   32'd0);
        chk("arst_in_ready", 32'(in_ready),  32'd1);
        rstn = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
